// File: rtl/sprite_line_scheduler_pkg.sv
// Shared definitions for the multi-sprite line scheduler: FSM state and
// attribute field encodings, default geometry, the sprite attribute record
// and small slot-mask helpers.
package sprite_line_scheduler_pkg;

  // Hardware slot count; the scheduler may scan fewer via NUM_SPRITES.
  localparam int MAX_SPRITES      = 8;
  localparam int NUM_SPRITES_DEF  = 8;
  localparam int LR_DEPTH_DEF     = 256;
  localparam int H_ACTIVE_DEF     = 640;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SCAN  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NUM = 2'd0,
    FIELD_X   = 2'd1,
    FIELD_Y   = 2'd2,
    FIELD_EN  = 2'd3
  } attr_field_e;

  typedef struct packed {
    logic [5:0] num;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } sprite_attr_t;

  typedef logic [MAX_SPRITES-1:0] slot_mask_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } slot_pick_t;

  // Highest set bit of a slot mask; valid is clear when the mask is empty.
  function automatic slot_pick_t highest_slot(input slot_mask_t mask);
    slot_pick_t pick;
    pick = '0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      if (mask[i]) begin
        pick.valid = 1'b1;
        pick.idx   = 3'(i);
      end
    end
    return pick;
  endfunction

  // Number of set bits in a slot mask (0..8).
  function automatic logic [3:0] count_hits(input slot_mask_t mask);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      if (mask[i]) n = n + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one CPU write port that updates a single
// field of one slot, and one combinational indexed read port returning the
// whole record for the scheduler.
module sprite_attr_table
  import sprite_line_scheduler_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         write_i,
  input  logic [2:0]   write_index_i,
  input  logic [1:0]   write_field_i,
  input  logic [9:0]   write_data_i,
  input  logic [2:0]   read_index_i,
  output sprite_attr_t read_attr_o
);

  sprite_attr_t table_q [MAX_SPRITES];

  // Field-wise table update; reset clears every slot, disabling all sprites.
  // NOTE: this storage is reset deliberately because a cleared, all-disabled
  // table is part of the block's defined reset state; a plain data RAM would
  // be left unreset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        table_q[i] <= '0;
      end
    end else if (write_i) begin
      case (attr_field_e'(write_field_i))
        FIELD_NUM: table_q[write_index_i].num <= write_data_i[5:0];
        FIELD_X:   table_q[write_index_i].x   <= write_data_i;
        FIELD_Y:   table_q[write_index_i].y   <= write_data_i;
        FIELD_EN:  table_q[write_index_i].en  <= write_data_i[0];
        default:   ;
      endcase
    end
  end

  assign read_attr_o = table_q[read_index_i];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Multi-sprite line renderer. On each line_start it clears the back bank of
// the ping-pong line RAM, scans the attribute table for sprites crossing the
// requested row, then streams each hit sprite's eight ROM pixels into the
// bank, lowest slot last so slot 0 wins overlaps.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int LR_DEPTH    = LR_DEPTH_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_start,
  input  logic [9:0] next_row,
  input  logic       attr_write,
  input  logic [2:0] attr_index,
  input  logic [1:0] attr_field,
  input  logic [9:0] attr_data,
  output logic [5:0] rom_sprite_num,
  output logic [2:0] rom_row,
  output logic [2:0] rom_col,
  input  logic [1:0] rom_pixel,
  output logic       lr_write,
  output logic [8:0] lr_addr,
  output logic [1:0] lr_data,
  output logic       busy,
  output logic       overrun,
  output logic [3:0] hit_count
);

  localparam logic [7:0] CLEAR_LAST  = 8'(LR_DEPTH - 1);
  localparam logic [2:0] SLOT_LAST   = 3'(NUM_SPRITES - 1);
  localparam slot_mask_t ACTIVE_MASK = slot_mask_t'((1 << NUM_SPRITES) - 1);

  state_e     state_q, state_d;
  logic [9:0] row_q, row_d;           // row being rendered; bit 1 selects the bank
  logic [7:0] clr_q, clr_d;           // CLEAR entry counter
  logic [2:0] slot_q, slot_d;         // SCAN slot counter
  logic [2:0] fslot_q, fslot_d;       // slot currently being fetched
  logic [2:0] k_q, k_d;               // pixel column within the sprite
  slot_mask_t hit_q, hit_d;
  logic [2:0] row_lat_q [MAX_SPRITES];
  logic [2:0] row_lat_d [MAX_SPRITES];
  logic       pend_q, pend_d;         // a ROM read is returning this cycle
  logic       on_q, on_d;             // that pixel lands on screen
  logic [8:0] paddr_q, paddr_d;       // line RAM address for that pixel
  logic       overrun_q, overrun_d;
  logic [3:0] hits_q, hits_d;

  sprite_attr_t attr;
  logic [2:0]   rd_index;
  logic [9:0]   dy;
  logic         scan_hit;
  logic [10:0]  pix_col;
  slot_mask_t   lower_mask;
  slot_pick_t   pick;
  logic         clearing;
  logic         fetching;
  logic         fetch_write;

  sprite_attr_table u_table (
    .clock         (clock),
    .reset         (reset),
    .write_i       (attr_write),
    .write_index_i (attr_index),
    .write_field_i (attr_field),
    .write_data_i  (attr_data),
    .read_index_i  (rd_index),
    .read_attr_o   (attr)
  );

  assign clearing   = (state_q == ST_CLEAR);
  assign fetching   = (state_q == ST_FETCH);
  assign rd_index   = (state_q == ST_SCAN) ? slot_q : fslot_q;
  assign dy         = row_q - attr.y;
  assign scan_hit   = attr.en && (dy < 10'd16);
  assign pix_col    = {1'b0, attr.x} + {7'd0, k_q, 1'b0};
  assign lower_mask = slot_mask_t'((9'd1 << fslot_q) - 9'd1);

  // Next-state logic for the FSM, counters, hit mask and ROM-return pipe.
  // NOTE: every _d gets a default before the case so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    clr_d     = clr_q;
    slot_d    = slot_q;
    fslot_d   = fslot_q;
    k_d       = k_q;
    hit_d     = hit_q;
    row_lat_d = row_lat_q;
    pend_d    = 1'b0;
    on_d      = 1'b0;
    paddr_d   = '0;
    overrun_d = overrun_q;
    hits_d    = hits_q;
    pick      = '0;

    case (state_q)
      ST_IDLE: ;
      ST_CLEAR: begin
        clr_d = clr_q + 8'd1;
        if (clr_q == CLEAR_LAST) begin
          state_d = ST_SCAN;
          slot_d  = '0;
        end
      end
      ST_SCAN: begin
        hit_d[slot_q]     = scan_hit;
        row_lat_d[slot_q] = dy[3:1];
        slot_d            = slot_q + 3'd1;
        if (slot_q == SLOT_LAST) begin
          pick = highest_slot(hit_d & ACTIVE_MASK);
          if (pick.valid) begin
            state_d = ST_FETCH;
            fslot_d = pick.idx;
            k_d     = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        pend_d  = 1'b1;
        on_d    = (pix_col < 11'(H_ACTIVE));
        paddr_d = {row_q[1], pix_col[8:1]};
        k_d     = k_q + 3'd1;
        if (k_q == 3'd7) begin
          pick = highest_slot(hit_q & lower_mask);
          if (pick.valid) fslot_d = pick.idx;
          else            state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hits_d  = count_hits(hit_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new line always wins: abort whatever is in flight, including the
    // pending ROM return, so nothing more reaches the old row.
    if (line_start) begin
      state_d = ST_CLEAR;
      row_d   = next_row;
      clr_d   = '0;
      hit_d   = '0;
      k_d     = '0;
      pend_d  = 1'b0;
      if (state_q != ST_IDLE) overrun_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      clr_q     <= '0;
      slot_q    <= '0;
      fslot_q   <= '0;
      k_q       <= '0;
      hit_q     <= '0;
      for (int i = 0; i < MAX_SPRITES; i++) row_lat_q[i] <= '0;
      pend_q    <= 1'b0;
      on_q      <= 1'b0;
      paddr_q   <= '0;
      overrun_q <= 1'b0;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      clr_q     <= clr_d;
      slot_q    <= slot_d;
      fslot_q   <= fslot_d;
      k_q       <= k_d;
      hit_q     <= hit_d;
      row_lat_q <= row_lat_d;
      pend_q    <= pend_d;
      on_q      <= on_d;
      paddr_q   <= paddr_d;
      overrun_q <= overrun_d;
      hits_q    <= hits_d;
    end
  end

  // ROM address is only driven while fetching so idle outputs stay at zero.
  assign rom_sprite_num = fetching ? attr.num : '0;
  assign rom_row        = fetching ? row_lat_q[fslot_q] : '0;
  assign rom_col        = fetching ? k_q : '0;

  // The ROM pixel arrives one cycle after its address; transparent and
  // off-screen pixels are dropped.
  assign fetch_write = pend_q && on_q && (rom_pixel != 2'b00);
  assign lr_write    = clearing || fetch_write;
  assign lr_addr     = clearing    ? {row_q[1], clr_q} :
                       fetch_write ? paddr_q : '0;
  assign lr_data     = fetch_write ? rom_pixel : '0;

  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign hit_count = hits_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler. A behavioural ROM answers one
// cycle after each address; a monitor logs every line RAM write with its
// cycle number relative to the most recent line_start.
module tb_sprite_line_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       line_start;
  logic [9:0] next_row;
  logic       attr_write;
  logic [2:0] attr_index;
  logic [1:0] attr_field;
  logic [9:0] attr_data;
  logic [5:0] rom_sprite_num;
  logic [2:0] rom_row;
  logic [2:0] rom_col;
  logic [1:0] rom_pixel;
  logic       lr_write;
  logic [8:0] lr_addr;
  logic [1:0] lr_data;
  logic       busy;
  logic       overrun;
  logic [3:0] hit_count;

  sprite_line_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .line_start     (line_start),
    .next_row       (next_row),
    .attr_write     (attr_write),
    .attr_index     (attr_index),
    .attr_field     (attr_field),
    .attr_data      (attr_data),
    .rom_sprite_num (rom_sprite_num),
    .rom_row        (rom_row),
    .rom_col        (rom_col),
    .rom_pixel      (rom_pixel),
    .lr_write       (lr_write),
    .lr_addr        (lr_addr),
    .lr_data        (lr_data),
    .busy           (busy),
    .overrun        (overrun),
    .hit_count      (hit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t        wq[$];
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_busy = -1;
  logic [2:0] row_seen;
  logic [5:0] num_seen;
  int         tests = 0;
  int         fails = 0;

  // Sprite 63 is fully transparent; every other sprite is fully opaque with a
  // pattern that differs between neighbouring sprite numbers.
  function automatic logic [1:0] rom_fn(input logic [5:0] n, input logic [2:0] r,
                                        input logic [2:0] c);
    if (n == 6'd63) return 2'd0;
    return 2'(((int'(n) * 5 + int'(r) * 3 + int'(c)) % 3) + 1);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rom_pixel <= rom_fn(rom_sprite_num, rom_row, rom_col);

  always @(negedge clock) begin
    if (lr_write) wq.push_back('{cyc - start_cyc, lr_addr, lr_data});
    if (busy) last_busy = cyc - start_cyc;
    if (cyc - start_cyc == 265) begin
      row_seen = rom_row;
      num_seen = rom_sprite_num;
    end
  end

  // Mismatches among 256 logged writes starting at wq[base] against a clear
  // of the given bank beginning on first_cyc.
  function automatic int clear_errors(input int base, input logic bank, input int first_cyc);
    int bad = 0;
    if (wq.size() < base + 256) return 256;
    for (int i = 0; i < 256; i++) begin
      if (wq[base+i].cyc != first_cyc + i || wq[base+i].addr !== {bank, 8'(i)} ||
          wq[base+i].data !== 2'd0) bad++;
    end
    return bad;
  endfunction

  // Mismatches among cnt logged sprite writes starting at wq[base].
  function automatic int fetch_errors(input int base, input logic bank, input int entry0,
                                      input logic [5:0] n, input logic [2:0] r,
                                      input int first_cyc, input int cnt);
    int bad = 0;
    if (wq.size() < base + cnt) return cnt;
    for (int k = 0; k < cnt; k++) begin
      if (wq[base+k].cyc != first_cyc + k || wq[base+k].addr !== {bank, 8'(entry0 + k)} ||
          wq[base+k].data !== rom_fn(n, r, 3'(k))) bad++;
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_attr(input int idx, input int field, input int data);
    attr_write = 1'b1;
    attr_index = 3'(idx);
    attr_field = 2'(field);
    attr_data  = 10'(data);
    tick();
    attr_write = 1'b0;
  endtask

  task automatic set_sprite(input int idx, input int n, input int x, input int y, input int en);
    write_attr(idx, 0, n);
    write_attr(idx, 1, x);
    write_attr(idx, 2, y);
    write_attr(idx, 3, en);
  endtask

  task automatic start_line(input int row);
    next_row   = 10'(row);
    line_start = 1'b1;
    start_cyc  = cyc;
    last_busy  = -1;
    row_seen   = '0;
    num_seen   = '0;
    wq.delete();
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests++;
    if ({busy, lr_write, overrun} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: busy/lr_write/overrun=%b expected 000", {busy, lr_write, overrun});
    end
    tests++;
    if ({lr_addr, lr_data, hit_count} !== '0) begin
      fails++;
      $display("FAIL reset_data: lr_addr=%0d lr_data=%0d hit_count=%0d expected 0",
               lr_addr, lr_data, hit_count);
    end
    tests++;
    if ({rom_sprite_num, rom_row, rom_col} !== '0) begin
      fails++;
      $display("FAIL reset_rom: num=%0d row=%0d col=%0d expected 0", rom_sprite_num, rom_row, rom_col);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_clear_no_hits();
    int e;
    start_line(5);
    wait_idle("clear");
    tests++;
    if (wq.size() != 256) begin
      fails++;
      $display("FAIL clear_count: %0d writes, expected 256", wq.size());
    end
    e = clear_errors(0, 1'b0, 1);
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL clear_writes: %0d bad entries, expected 0", e);
    end
    tests++;
    if (hit_count !== 4'd0) begin
      fails++;
      $display("FAIL clear_hits: hit_count=%0d expected 0", hit_count);
    end
    tests++;
    if (last_busy != 265) begin
      fails++;
      $display("FAIL clear_busy: last busy cycle %0d expected 265", last_busy);
    end
  endtask

  task automatic test_single_sprite();
    int e;
    set_sprite(2, 3, 100, 0, 1);
    start_line(6);
    wait_idle("single");
    tests++;
    if (row_seen !== 3'd3 || num_seen !== 6'd3) begin
      fails++;
      $display("FAIL single_rom_addr: row=%0d num=%0d expected row 3 num 3", row_seen, num_seen);
    end
    tests++;
    if (wq.size() != 264) begin
      fails++;
      $display("FAIL single_count: %0d writes, expected 264", wq.size());
    end
    e = clear_errors(0, 1'b1, 1) + fetch_errors(256, 1'b1, 50, 6'd3, 3'd3, 266, 8);
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL single_writes: %0d bad entries, expected 0", e);
    end
    tests++;
    if (hit_count !== 4'd1 || last_busy != 273) begin
      fails++;
      $display("FAIL single_done: hit_count=%0d last_busy=%0d expected 1 and 273", hit_count, last_busy);
    end
  endtask

  task automatic test_priority();
    int e;
    write_attr(2, 3, 0);
    set_sprite(0, 5, 40, 10, 1);
    set_sprite(1, 6, 40, 10, 1);
    start_line(12);
    wait_idle("priority");
    tests++;
    if (wq.size() != 272) begin
      fails++;
      $display("FAIL priority_count: %0d writes, expected 272", wq.size());
    end
    e = fetch_errors(256, 1'b0, 20, 6'd6, 3'd1, 266, 8);
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL priority_slot1_first: %0d bad entries, expected 0", e);
    end
    e = fetch_errors(264, 1'b0, 20, 6'd5, 3'd1, 274, 8);
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL priority_slot0_last: %0d bad entries, expected 0", e);
    end
    tests++;
    if (hit_count !== 4'd2 || last_busy != 281) begin
      fails++;
      $display("FAIL priority_done: hit_count=%0d last_busy=%0d expected 2 and 281", hit_count, last_busy);
    end
  endtask

  task automatic test_right_edge();
    int e;
    write_attr(1, 3, 0);
    set_sprite(0, 7, 636, 0, 1);
    start_line(0);
    wait_idle("edge");
    tests++;
    if (wq.size() != 258) begin
      fails++;
      $display("FAIL edge_count: %0d writes, expected 258", wq.size());
    end
    e = fetch_errors(256, 1'b0, 62, 6'd7, 3'd0, 266, 2);
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL edge_writes: %0d bad entries, expected 0", e);
    end
    tests++;
    if (hit_count !== 4'd1 || last_busy != 273) begin
      fails++;
      $display("FAIL edge_done: hit_count=%0d last_busy=%0d expected 1 and 273", hit_count, last_busy);
    end
  endtask

  task automatic test_wrap();
    int e;
    set_sprite(0, 7, 0, 1020, 1);
    start_line(2);
    wait_idle("wrap_hit");
    e = fetch_errors(256, 1'b1, 0, 6'd7, 3'd3, 266, 8);
    tests++;
    if (row_seen !== 3'd3 || hit_count !== 4'd1 || e != 0) begin
      fails++;
      $display("FAIL wrap_hit: row=%0d hit_count=%0d bad=%0d expected 3, 1, 0", row_seen, hit_count, e);
    end
    start_line(20);
    wait_idle("wrap_miss");
    tests++;
    if (hit_count !== 4'd0 || wq.size() != 256 || last_busy != 265) begin
      fails++;
      $display("FAIL wrap_miss: hit_count=%0d writes=%0d last_busy=%0d expected 0, 256, 265",
               hit_count, wq.size(), last_busy);
    end
  endtask

  task automatic test_transparent();
    write_attr(0, 0, 63);
    write_attr(0, 2, 0);
    start_line(4);
    wait_idle("transparent");
    tests++;
    if (wq.size() != 256 || hit_count !== 4'd1 || last_busy != 273) begin
      fails++;
      $display("FAIL transparent: writes=%0d hit_count=%0d last_busy=%0d expected 256, 1, 273",
               wq.size(), hit_count, last_busy);
    end
  endtask

  task automatic test_abort_and_reset();
    int e;
    int stale;
    write_attr(0, 0, 7);
    start_line(6);
    while (cyc - start_cyc < 100) tick();
    next_row   = 10'd0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_idle("abort");
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL abort_overrun: overrun=%b expected 1", overrun);
    end
    stale = 0;
    foreach (wq[i]) if (wq[i].cyc > 100 && wq[i].addr[8] == 1'b1) stale++;
    tests++;
    if (stale != 0 || wq.size() != 364) begin
      fails++;
      $display("FAIL abort_stale: stale=%0d writes=%0d expected 0 and 364", stale, wq.size());
    end
    e = clear_errors(100, 1'b0, 101) + fetch_errors(356, 1'b0, 0, 6'd7, 3'd0, 366, 8);
    tests++;
    if (e != 0 || hit_count !== 4'd1 || last_busy != 373) begin
      fails++;
      $display("FAIL abort_restart: bad=%0d hit_count=%0d last_busy=%0d expected 0, 1, 373",
               e, hit_count, last_busy);
    end

    start_line(4);
    repeat (50) tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({busy, lr_write, overrun, lr_addr, lr_data, hit_count, rom_sprite_num, rom_row, rom_col} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: busy=%b lr_write=%b overrun=%b lr_addr=%0d hit_count=%0d expected all 0",
               busy, lr_write, overrun, lr_addr, hit_count);
    end
    reset = 1'b1;
    tick();
    start_line(0);
    wait_idle("table_cleared");
    tests++;
    if (hit_count !== 4'd0 || wq.size() != 256 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL table_cleared: hit_count=%0d writes=%0d overrun=%b expected 0, 256, 0",
               hit_count, wq.size(), overrun);
    end
  endtask

  initial begin
    reset      = 1'b0;
    line_start = 1'b0;
    next_row   = '0;
    attr_write = 1'b0;
    attr_index = '0;
    attr_field = '0;
    attr_data  = '0;
    test_reset();
    test_clear_no_hits();
    test_single_sprite();
    test_priority();
    test_right_edge();
    test_wrap();
    test_transparent();
    test_abort_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
